// File: rtl/vga_src_arb.sv
// vga_src_arb: selects one of two AXI4-Stream video sources (or, optionally, an
// internal colour-bar generator) and forwards it to a VGA timing core.
//
// The output stream is kept frame-aligned. After reset, after a source change,
// or after a framing error, the block waits in SYNC for a start-of-frame beat
// (tuser=1) and drops every other beat of the active source. In PASS the active
// source is passed through combinationally. The beat is also checked against a
// raster position counter (x, y) for correct tlast/tuser placement.
//
// Source selection is sampled every cycle into a pending register. The pending
// value only takes effect at the end of a frame, or at any time while in SYNC,
// so a switch never tears a frame.
//
// Optional feature: define VGA_SRC_ARB_TPG_EN to build in an 8-bar colour test
// pattern that is selected with sel=2. Without the macro, sel=2 selects s0.
//
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   s0_* / s1_*               AXI4-Stream pixel sources (tdata = {r,g,b} 4b each,
//                             tlast = end of line, tuser = start of frame)
//   m_*                       AXI4-Stream pixel output
//   sel                       requested source (0=s0, 1=s1, 2=pattern, 3=s0)
//   active_src                source currently driving m_*
//   frame_err                 one-cycle pulse on a tlast/tuser placement error

module vga_src_arb #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic [11:0] s0_tdata,
    input  logic        s0_tlast,
    input  logic        s0_tuser,

    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic [11:0] s1_tdata,
    input  logic        s1_tlast,
    input  logic        s1_tuser,

    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [11:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tuser,

    input  logic [1:0]  sel,
    output logic [1:0]  active_src,
    output logic        frame_err
);

    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    localparam logic [1:0] SRC_S0 = 2'd0;
    localparam logic [1:0] SRC_S1 = 2'd1;
`ifdef VGA_SRC_ARB_TPG_EN
    localparam logic [1:0] SRC_TPG = 2'd2;
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
`endif

    typedef enum logic {
        SYNC,
        PASS
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    pending;

    // Selected external source, before SYNC gating
    logic          src_valid;
    logic [11:0]   src_data;
    logic          src_last;
    logic          src_user;
    logic          src_ready;

    logic          at_x_last;
    logic          at_origin;
    logic          at_eof;
    logic          xfer;
    logic          violation;
    logic          is_tpg;
    logic          pending_is_tpg;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    // sel=3 always folds onto s0; sel=2 does too unless the pattern is built in
    function automatic logic [1:0] map_sel(input logic [1:0] s);
        logic [1:0] r;
        r = SRC_S0;
        if (s == SRC_S1) begin
            r = SRC_S1;
        end
`ifdef VGA_SRC_ARB_TPG_EN
        if (s == SRC_TPG) begin
            r = SRC_TPG;
        end
`endif
        return r;
    endfunction

`ifdef VGA_SRC_ARB_TPG_EN
    assign is_tpg         = (active_src == SRC_TPG);
    assign pending_is_tpg = (pending == SRC_TPG);

    logic [11:0] tpg_color;
    always_comb begin
        int unsigned bar;
        bar = 32'(x) / BAR_W;
        case (bar)
            0:       tpg_color = 12'hFFF;
            1:       tpg_color = 12'hFF0;
            2:       tpg_color = 12'h0FF;
            3:       tpg_color = 12'h0F0;
            4:       tpg_color = 12'hF0F;
            5:       tpg_color = 12'hF00;
            6:       tpg_color = 12'h00F;
            default: tpg_color = 12'h000;
        endcase
    end
`else
    assign is_tpg         = 1'b0;
    assign pending_is_tpg = 1'b0;
`endif

    assign at_x_last = (x == X_LAST);
    assign at_origin = (x == '0) && (y == '0);
    assign at_eof    = at_x_last && (y == Y_LAST);

    always_comb begin
        if (active_src == SRC_S1) begin
            src_valid = s1_tvalid;
            src_data  = s1_tdata;
            src_last  = s1_tlast;
            src_user  = s1_tuser;
        end else begin
            src_valid = s0_tvalid;
            src_data  = s0_tdata;
            src_last  = s0_tlast;
            src_user  = s0_tuser;
        end
    end

    always_comb begin
        m_tvalid  = src_valid;
        m_tdata   = src_data;
        m_tlast   = src_last;
        m_tuser   = src_user;
        src_ready = m_tready;
        // While hunting for start of frame, swallow everything else
        if (state == SYNC && !src_user) begin
            m_tvalid  = 1'b0;
            src_ready = 1'b1;
        end
`ifdef VGA_SRC_ARB_TPG_EN
        if (is_tpg) begin
            m_tvalid  = 1'b1;
            m_tdata   = tpg_color;
            m_tlast   = at_x_last;
            m_tuser   = at_origin;
            src_ready = 1'b1;
        end
`endif
        s0_tready = 1'b1;
        s1_tready = 1'b1;
        if (active_src == SRC_S1) begin
            s1_tready = src_ready;
        end else if (active_src == SRC_S0) begin
            s0_tready = src_ready;
        end
        if (areset) begin
            m_tvalid  = 1'b0;
            s0_tready = 1'b0;
            s1_tready = 1'b0;
        end
    end

    assign xfer      = m_tvalid && m_tready;
    assign violation = xfer && (state == PASS) && !is_tpg &&
                       ((src_last != at_x_last) || (src_user != at_origin));

    always_comb begin
        x_nxt = x + XW'(1);
        y_nxt = y;
        if (at_x_last) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? '0 : y + YW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= SYNC;
            x          <= '0;
            y          <= '0;
            active_src <= SRC_S0;
            pending    <= SRC_S0;
            frame_err  <= 1'b0;
        end else begin
            pending   <= map_sel(sel);
            frame_err <= 1'b0;
            if (state == SYNC && pending != active_src) begin
                // Nothing is in flight yet, so a new selection applies at once
                active_src <= pending;
                x          <= '0;
                y          <= '0;
                state      <= pending_is_tpg ? PASS : SYNC;
            end else if (xfer) begin
                if (at_eof && pending != active_src) begin
                    // Frame boundary switch wins over a coincident framing error
                    active_src <= pending;
                    x          <= '0;
                    y          <= '0;
                    state      <= pending_is_tpg ? PASS : SYNC;
                    frame_err  <= violation;
                end else if (violation) begin
                    frame_err <= 1'b1;
                    x         <= '0;
                    y         <= '0;
                    state     <= SYNC;
                end else begin
                    // Also covers the SYNC start-of-frame beat, since SYNC holds x=y=0
                    x     <= x_nxt;
                    y     <= y_nxt;
                    state <= PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_src_arb.sv
`timescale 1ns/1ps
module tb_vga_src_arb;

    localparam int H = 16;
    localparam int V = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
    logic [11:0] s0_tdata;
    logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic [11:0] s1_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [11:0] m_tdata;
    logic [1:0]  sel, active_src;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int rx = 0;
    int ry = 0;
    int xfers = 0;

    vga_src_arb #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .aclk(aclk), .areset(areset),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
        .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
        .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .sel(sel), .active_src(active_src), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [11:0] pix(input int px, input int py);
        logic [11:0] p;
        p = {4'(py), 8'(px)};
        return p;
    endfunction

    task automatic advance();
        rx++;
        if (rx == H) begin
            rx = 0;
            ry++;
            if (ry == V) ry = 0;
        end
    endtask

    // Feeds n correctly framed beats on src from the reference position (rx, ry),
    // while the other source babbles randomly; checks pass-through every cycle.
    task automatic stream(input int src, input int n, input bit rnd);
        int sent = 0;
        int guard = 0;
        logic [11:0] p;
        logic u, l, ov;
        while (sent < n && guard < 4000) begin
            p  = pix(rx, ry);
            u  = (rx == 0 && ry == 0);
            l  = (rx == H - 1);
            ov = 1'($urandom_range(0, 1));
            if (src == 0) begin
                s0_tvalid = 1'b1; s0_tdata = p; s0_tlast = l; s0_tuser = u;
                s1_tvalid = ov; s1_tdata = 12'($urandom); s1_tlast = 1'b0;
                s1_tuser = 1'($urandom_range(0, 1));
            end else begin
                s1_tvalid = 1'b1; s1_tdata = p; s1_tlast = l; s1_tuser = u;
                s0_tvalid = ov; s0_tdata = 12'($urandom); s0_tlast = 1'b0;
                s0_tuser = 1'($urandom_range(0, 1));
            end
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #3;
            chk("str_mvalid", m_tvalid, 1);
            chk("str_mdata", m_tdata, p);
            chk("str_muser", m_tuser, u);
            chk("str_mlast", m_tlast, l);
            chk("str_src_ready", (src == 0) ? s0_tready : s1_tready, m_tready);
            chk("str_other_ready", (src == 0) ? s1_tready : s0_tready, 1);
            chk("str_ferr", frame_err, 0);
            if (m_tvalid && m_tready) xfers++;
            if (m_tready) begin
                sent++;
                advance();
            end
            next_cycle();
            guard++;
        end
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        if (sent < n) chk("str_timeout", sent, n);
    endtask

    typedef struct {
        logic        s0v;
        logic [11:0] s0d;
        logic        s0u;
        logic        s1v;
        logic        s1u;
        logic        mrdy;
        logic        mv;
        logic [11:0] md;
        logic        mu;
        logic        r0;
        logic        r1;
    } vec_t;

    vec_t vt[8];
    logic [11:0] bars[8];

    initial begin
        // SYNC junk drop, start-of-frame stall/transfer, PASS idle and stall
        vt[0] = '{1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1};
        vt[1] = '{1'b1, 12'h456, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 12'h789, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1};
        vt[5] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1};
        vt[7] = '{1'b1, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 1'b1};
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

        s0_tvalid = 1'b1; s0_tdata = 12'h000; s0_tlast = 1'b0; s0_tuser = 1'b1;
        s1_tvalid = 1'b1; s1_tdata = 12'h000; s1_tlast = 1'b0; s1_tuser = 1'b1;
        m_tready = 1'b1; sel = 2'd0;
        next_cycle();
        next_cycle();
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_s0_ready", s0_tready, 0);
        chk("rst_s1_ready", s1_tready, 0);
        chk("rst_active", active_src, 0);
        chk("rst_ferr", frame_err, 0);
        areset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            s0_tvalid = vt[i].s0v; s0_tdata = vt[i].s0d; s0_tuser = vt[i].s0u; s0_tlast = 1'b0;
            s1_tvalid = vt[i].s1v; s1_tdata = 12'h777; s1_tuser = vt[i].s1u; s1_tlast = 1'b0;
            m_tready = vt[i].mrdy;
            #3;
            chk($sformatf("vec%0d_mvalid", i), m_tvalid, vt[i].mv);
            chk($sformatf("vec%0d_s0_ready", i), s0_tready, vt[i].r0);
            chk($sformatf("vec%0d_s1_ready", i), s1_tready, vt[i].r1);
            chk($sformatf("vec%0d_active", i), active_src, 0);
            if (vt[i].mv) begin
                chk($sformatf("vec%0d_mdata", i), m_tdata, vt[i].md);
                chk($sformatf("vec%0d_muser", i), m_tuser, vt[i].mu);
            end
            next_cycle();
        end
        rx = 1; ry = 0;

        // Rest of frame then part of the next with random backpressure
        xfers = 0;
        stream(0, 31, 1'b1);
        stream(0, 20, 1'b1);
        chk("xfer_count", xfers, 51);

        // Source change requested mid-frame waits for the last pixel
        sel = 2'd1;
        stream(0, 11, 1'b1);
        chk("sw_hold_active", active_src, 0);
        stream(0, 1, 1'b0);
        chk("sw_new_active", active_src, 1);
        s1_tvalid = 1'b1; s1_tdata = 12'hABC; s1_tuser = 1'b0; s1_tlast = 1'b0;
        s0_tvalid = 1'b1; m_tready = 1'b1;
        #3;
        chk("sw_sync_drop", m_tvalid, 0);
        chk("sw_sync_s1_ready", s1_tready, 1);
        chk("sw_sync_s0_ready", s0_tready, 1);
        next_cycle();
        stream(1, 32, 1'b1);

        // Early tlast at x=5
        stream(1, 5, 1'b0);
        s1_tvalid = 1'b1; s1_tdata = pix(5, 0); s1_tlast = 1'b1; s1_tuser = 1'b0;
        s0_tvalid = 1'b0; m_tready = 1'b1;
        #3;
        chk("err_mvalid", m_tvalid, 1);
        chk("err_s1_ready", s1_tready, 1);
        next_cycle();
        chk("err_pulse", frame_err, 1);
        s1_tdata = pix(6, 0); s1_tlast = 1'b0;
        #3;
        chk("err_sync_drop", m_tvalid, 0);
        chk("err_sync_ready", s1_tready, 1);
        next_cycle();
        chk("err_pulse_end", frame_err, 0);
        rx = 0; ry = 0;
        stream(1, 3, 1'b0);

        // Reset mid-line
        sel = 2'd0;
        stream(1, 7, 1'b0);
        s1_tvalid = 1'b1; s1_tdata = pix(10, 0); s1_tlast = 1'b0; s1_tuser = 1'b0;
        m_tready = 1'b1;
        areset = 1'b1;
        #1;
        chk("mrst_mvalid", m_tvalid, 0);
        chk("mrst_s0_ready", s0_tready, 0);
        chk("mrst_s1_ready", s1_tready, 0);
        chk("mrst_active", active_src, 0);
        chk("mrst_ferr", frame_err, 0);
        next_cycle();
        areset = 1'b0;
        s1_tvalid = 1'b0;
        s0_tvalid = 1'b1; s0_tdata = pix(10, 0); s0_tuser = 1'b0;
        #3;
        chk("mrst_sync_drop", m_tvalid, 0);
        chk("mrst_sync_ready", s0_tready, 1);
        next_cycle();

        sel = 2'd3;
        next_cycle();
        next_cycle();
        chk("sel3_active", active_src, 0);
        chk("sel3_still_sync", m_tvalid, 0);
`ifndef VGA_SRC_ARB_TPG_EN
        sel = 2'd2;
        next_cycle();
        next_cycle();
        chk("sel2_active", active_src, 0);
`endif
        sel = 2'd0;
        next_cycle();
        rx = 0; ry = 0;
        stream(0, 4, 1'b0);

`ifdef VGA_SRC_ARB_TPG_EN
        sel = 2'd2;
        stream(0, 28, 1'b0);
        chk("tpg_active", active_src, 2);
        begin
            int sent = 0;
            int guard = 0;
            while (sent < H * V && guard < 4000) begin
                s0_tvalid = 1'($urandom_range(0, 1)); s0_tuser = 1'b0;
                s1_tvalid = 1'($urandom_range(0, 1)); s1_tuser = 1'b0;
                m_tready = 1'($urandom_range(0, 1));
                #3;
                chk("tpg_mvalid", m_tvalid, 1);
                chk("tpg_mdata", m_tdata, bars[rx / (H / 8)]);
                chk("tpg_muser", m_tuser, (rx == 0 && ry == 0));
                chk("tpg_mlast", m_tlast, (rx == H - 1));
                chk("tpg_s0_ready", s0_tready, 1);
                chk("tpg_s1_ready", s1_tready, 1);
                chk("tpg_ferr", frame_err, 0);
                if (m_tready) begin
                    sent++;
                    advance();
                end
                next_cycle();
                guard++;
            end
            if (sent < H * V) chk("tpg_timeout", sent, H * V);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
